// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM state encoding and the frame parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Wide enough for any supported data width; zero-extension leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 16;

    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick_o marks the last clk_i cycle of every CLKS_PER_BIT-cycle bit period.
// clr_i holds the count at zero so the first period starts cleanly on the following cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tick_o = (cnt_q == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DW data bits, optional parity, 1-2 stop bits; serial line is registered.
// Word accepted when valid_i && ready_o; ready_o only in IDLE with en_i high; en_i low aborts the frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic          serial_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int CW = $clog2(DW);

    tx_state_e     state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic          serial_q, serial_d;
    logic          done_d;
    logic          tick;
    logic          accept;
    logic          timer_clr;
    logic [DW-1:0] data_ord;

    assign ready_o   = (state_q == IDLE) && en_i;
    assign accept    = valid_i && ready_o;
    assign busy_o    = (state_q != IDLE);
    assign serial_o  = serial_q;
    assign done_o    = done_d && !rst_i;
    assign timer_clr = (state_q == IDLE) || !en_i;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (timer_clr),
        .tick_o(tick)
    );

    // The shifter always emits bit 0, so MSB-first words are stored bit-reversed.
    always_comb begin
        data_ord = data_i;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < DW; i++) begin
                data_ord[i] = data_i[DW-1-i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = data_ord;
                    bit_cnt_d = '0;
                    par_d     = (PARITY_EN != 0) ?
                                calc_parity(PAR_MAX_W'(data_i), PARITY_ODD != 0) : 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CW'(DW - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == CW'(STOP_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (!en_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    // Line level is derived from the state being entered so serial_o changes on the same edge as the FSM.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            serial_q  <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four frame configurations driven by directed and random words,
// each serial waveform compared cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] en;
    logic [3:0] valid;
    logic [7:0] data;
    wire  [3:0] ready;
    wire  [3:0] serial;
    wire  [3:0] busy;
    wire  [3:0] done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 0: plain 8N1, 1: even parity, 2: odd parity, 3: two stop bits MSB first
    uart_tx_serializer #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                         .STOP_BITS(1), .MSB_FIRST(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .data_i(data), .valid_i(valid[0]),
        .ready_o(ready[0]), .serial_o(serial[0]), .busy_o(busy[0]), .done_o(done[0]));
    uart_tx_serializer #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0),
                         .STOP_BITS(1), .MSB_FIRST(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .data_i(data), .valid_i(valid[1]),
        .ready_o(ready[1]), .serial_o(serial[1]), .busy_o(busy[1]), .done_o(done[1]));
    uart_tx_serializer #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                         .STOP_BITS(1), .MSB_FIRST(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .en_i(en[2]), .data_i(data), .valid_i(valid[2]),
        .ready_o(ready[2]), .serial_o(serial[2]), .busy_o(busy[2]), .done_o(done[2]));
    uart_tx_serializer #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                         .STOP_BITS(2), .MSB_FIRST(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst[3]), .en_i(en[3]), .data_i(data), .valid_i(valid[3]),
        .ready_o(ready[3]), .serial_o(serial[3]), .busy_o(busy[3]), .done_o(done[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_par(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_odd(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int cfg_msb(input int k);
        return (k == 3) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int k);
        return CPB * (1 + 8 + cfg_par(k) + cfg_stop(k));
    endfunction

    // Level of bit period i of the frame carrying word d on configuration k.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return (cfg_msb(k) != 0) ? d[8-i] : d[i-1];
        if (cfg_par(k) != 0 && i == 9) return (cfg_odd(k) != 0) ? ~^d : ^d;
        return 1'b1;
    endfunction

    // Entered just after a negedge with the block idle; returns just after the negedge of the
    // first idle cycle. keep_valid leaves valid_i high so the caller's next word goes back-to-back.
    task automatic tx_frame(input int k, input logic [7:0] d, input bit keep_valid);
        int n;
        n = frame_len(k);
        data     = d;
        valid[k] = 1'b1;
        check_eq($sformatf("k%0d ready_before_accept", k), ready[k], 1);
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check_eq($sformatf("k%0d d%02h serial c%0d", k, d, c), serial[k], exp_bit(k, d, (c - 1) / CPB));
            check_eq($sformatf("k%0d busy c%0d", k, c), busy[k], 1);
            check_eq($sformatf("k%0d ready c%0d", k, c), ready[k], 0);
            check_eq($sformatf("k%0d done c%0d", k, c), done[k], (c == n) ? 1 : 0);
            data     = 8'($urandom);
            valid[k] = keep_valid ? 1'b1 : ((c == n) ? 1'b0 : 1'($urandom));
        end
        @(negedge clk);
        check_eq($sformatf("k%0d idle serial", k), serial[k], 1);
        check_eq($sformatf("k%0d idle busy", k), busy[k], 0);
        check_eq($sformatf("k%0d idle done", k), done[k], 0);
        check_eq($sformatf("k%0d idle ready", k), ready[k], 1);
    endtask

    // Starts a frame and kills it during cycle 'at' by dropping en_i or pulsing rst_i.
    task automatic tx_abort(input int k, input logic [7:0] d, input int at, input bit use_rst);
        data     = d;
        valid[k] = 1'b1;
        check_eq($sformatf("k%0d ready_before_abort_frame", k), ready[k], 1);
        @(posedge clk);
        for (int c = 1; c <= at; c++) begin
            @(negedge clk);
            valid[k] = 1'b0;
            check_eq($sformatf("k%0d abort serial c%0d", k, c), serial[k], exp_bit(k, d, (c - 1) / CPB));
            check_eq($sformatf("k%0d abort busy c%0d", k, c), busy[k], 1);
            check_eq($sformatf("k%0d abort done c%0d", k, c), done[k], 0);
            if (c == at) begin
                if (use_rst) rst[k] = 1'b1;
                else en[k] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq($sformatf("k%0d after_abort serial rst%0d", k, use_rst), serial[k], 1);
        check_eq($sformatf("k%0d after_abort busy rst%0d", k, use_rst), busy[k], 0);
        check_eq($sformatf("k%0d after_abort done rst%0d", k, use_rst), done[k], 0);
        if (use_rst) begin
            check_eq($sformatf("k%0d ready_in_reset_en1", k), ready[k], 1);
            en[k] = 1'b0;
            #1;
            check_eq($sformatf("k%0d ready_in_reset_en0", k), ready[k], 0);
            en[k]  = 1'b1;
            rst[k] = 1'b0;
        end else begin
            check_eq($sformatf("k%0d ready_while_disabled", k), ready[k], 0);
            en[k] = 1'b1;
        end
        #1;
    endtask

    initial begin
        int k;
        int mode;
        int gap;
        logic [7:0] d;

        rst   = 4'hF;
        en    = 4'h0;
        valid = 4'h0;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("k%0d reset serial", i), serial[i], 1);
            check_eq($sformatf("k%0d reset busy", i), busy[i], 0);
            check_eq($sformatf("k%0d reset done", i), done[i], 0);
            check_eq($sformatf("k%0d reset ready_en0", i), ready[i], 0);
        end
        en = 4'hF;
        #1;
        check_eq("ready_follows_en_in_reset", ready, 4'hF);
        @(negedge clk);
        rst = 4'h0;

        tx_frame(0, 8'hA5, 1'b0);
        tx_frame(1, 8'hA5, 1'b0);
        tx_frame(2, 8'hA5, 1'b0);
        tx_frame(3, 8'h81, 1'b0);
        tx_frame(0, 8'h00, 1'b1);
        tx_frame(0, 8'hFF, 1'b0);
        tx_abort(0, 8'h5A, 15, 1'b0);
        tx_frame(0, 8'h3C, 1'b0);
        tx_abort(1, 8'hC3, 12, 1'b1);
        tx_frame(1, 8'h96, 1'b0);

        for (int it = 0; it < 20; it++) begin
            k    = $urandom_range(0, 3);
            d    = 8'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                tx_abort(k, d, $urandom_range(1, frame_len(k) - 1), 1'b0);
            end else if (mode == 1) begin
                tx_abort(k, d, $urandom_range(1, frame_len(k) - 1), 1'b1);
            end else if (mode == 2) begin
                tx_frame(k, d, 1'b1);
                tx_frame(k, 8'($urandom), 1'b0);
            end else begin
                tx_frame(k, d, 1'b0);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_eq($sformatf("k%0d gap serial", k), serial[k], 1);
                check_eq($sformatf("k%0d gap busy", k), busy[k], 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
